// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: match mode and elaboration-time border / KMP fallback helpers
package seq_detect_pkg;

    typedef enum logic {NON_OVERLAP, OVERLAP} mode_e;

    // Longest proper prefix of the pattern that is also a suffix of it
    function automatic int border(logic [7:0] pat, int w);
        int r;
        logic ok;
        r = 0;
        for (int k = w - 1; k > 0; k--) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++)
                if (pat[w-1-j] != pat[k-1-j]) ok = 1'b0;
            if (ok && r == 0) r = k;
        end
        return r;
    endfunction

    // Next matched-prefix length after bit b arrives with s bits already matched
    function automatic int fallback(logic [7:0] pat, int w, int s, logic b, mode_e mode);
        int r;
        logic ok;
        logic rb;
        if (s == w - 1 && b == pat[0])
            return (mode == OVERLAP) ? border(pat, w) : 0;
        r = 0;
        for (int k = s + 1; k > 0; k--) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++) begin
                rb = (s + 1 - k + j < s) ? pat[w-1-(s+1-k+j)] : b;
                if (rb != pat[w-1-j]) ok = 1'b0;
            end
            if (ok && r == 0) r = k;
        end
        return r;
    endfunction

endpackage

// File: rtl/match_counter.sv
// match_counter: saturating event counter with synchronous clear
module match_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    assign sat = &cnt;

    always_ff @(posedge clk)
        cnt <= (rst || clr) ? '0 : (inc && !sat) ? cnt + CNT_W'(1) : cnt;

endmodule

// File: rtl/seq_detect_fsm.sv
// seq_detect_fsm: serial pattern detector with KMP fallback, match pulse and counter
module seq_detect_fsm
    import seq_detect_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] PATTERN = 4'b1011,
    parameter int               OVERLAP = 1,
    parameter int               CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     din,
    input  logic                     clr,
    output logic                     dout,
    output logic [$clog2(WIDTH)-1:0] state_o,
    output logic [CNT_W-1:0]         match_cnt,
    output logic                     cnt_sat
);

    localparam int    SW   = $clog2(WIDTH);
    localparam mode_e MODE = (OVERLAP != 0) ? seq_detect_pkg::OVERLAP : NON_OVERLAP;

    logic [SW-1:0] s;
    logic [SW-1:0] nxt;
    logic [SW-1:0] f0 [WIDTH];
    logic [SW-1:0] f1 [WIDTH];
    logic          hit;
    logic          hit_q;

    // Transition table per state and input bit, folded at elaboration
    for (genvar i = 0; i < WIDTH; i++) begin : g_tbl
        assign f0[i] = SW'(fallback(8'(PATTERN), WIDTH, i, 1'b0, MODE));
        assign f1[i] = SW'(fallback(8'(PATTERN), WIDTH, i, 1'b1, MODE));
    end

    assign hit = en && s == SW'(WIDTH - 1) && din == PATTERN[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            s     <= '0;
            hit_q <= 1'b0;
        end else begin
            s     <= nxt;
            hit_q <= hit;
        end
    end

    // Unused state codes fall back to 0
    always_comb begin
        nxt = '0;
        for (int k = 0; k < WIDTH; k++)
            if (s == SW'(k)) nxt = !en ? s : din ? f1[k] : f0[k];
    end

    always_comb begin
        dout    = hit_q;
        state_o = s;
    end

    match_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk(clk),
        .rst(rst),
        .inc(hit),
        .clr(clr),
        .cnt(match_cnt),
        .sat(cnt_sat)
    );

endmodule

// File: doc/seq_detect_fsm.md
SEQ_DETECT_FSM -- requirements
Module: seq_detect_fsm

Interface
REQ-001 SHALL have parameter WIDTH, default 4, pattern length in bits (legal 2..8).
REQ-002 SHALL have parameter PATTERN, default 4'b1011, WIDTH-bit target sequence, MSB received first.
REQ-003 SHALL have parameter OVERLAP, default 1: 1 = overlapping matches, 0 = non-overlapping.
REQ-004 SHALL have parameter CNT_W, default 8, match-counter width.
REQ-005 SHALL have port clk  input  1  sole clock, all state on posedge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port en  input  1  bit-valid; din consumed only on edges where en=1.
REQ-008 SHALL have port din  input  1  serial data bit.
REQ-009 SHALL have port clr  input  1  synchronous match-counter clear.
REQ-010 SHALL have port dout  output  1  registered one-cycle match pulse.
REQ-011 SHALL have port state_o  output  $clog2(WIDTH)  current matched-prefix length, for coverage.
REQ-012 SHALL have port match_cnt  output  CNT_W  number of matches since reset/clr.
REQ-013 SHALL have port cnt_sat  output  1  high while match_cnt is at all-ones.

Function
REQ-014 SHALL hold state S in 0..WIDTH-1, equal to the number of pattern prefix bits currently matched.
REQ-015 On an edge with en=1 and din==PATTERN[WIDTH-1-S] and S<WIDTH-1, SHALL set S to S+1.
REQ-016 On an edge with en=1 and din==PATTERN[WIDTH-1-S] and S==WIDTH-1 (match), SHALL set dout=1 for exactly the following cycle.
REQ-017 On a match with OVERLAP=1, SHALL set S to the longest proper border of PATTERN (prefix equal to suffix); with OVERLAP=0, SHALL set S to 0.
REQ-018 On an edge with en=1 and a mismatch, SHALL set S to the longest k<=S such that the last k received bits (matched prefix plus din) equal PATTERN's first k bits, KMP fallback.
REQ-019 On an edge with en=0, SHALL hold S and drive dout=0 the next cycle.
REQ-020 dout SHALL be 0 in every cycle not immediately following a match edge; back-to-back matches SHALL produce consecutive pulses.
REQ-021 Latency: dout SHALL rise in the cycle after the edge sampling the final pattern bit.
REQ-022 On each match edge, match_cnt SHALL increment by 1, saturating at 2^CNT_W-1 (no wrap).
REQ-023 cnt_sat SHALL be combinationally equal to (match_cnt == all-ones).
REQ-024 clr=1 SHALL set match_cnt to 0 on that edge; clr SHALL win over a simultaneous match, while S and dout still update normally.
REQ-025 state_o SHALL equal S at all times.

Reset
REQ-026 rst=1 at a posedge SHALL set S=0, dout=0, match_cnt=0, overriding en, din and clr.
REQ-027 rst asserted mid-pattern SHALL discard the partial match; detection SHALL restart from S=0 on the first edge after rst deasserts.

Structure
REQ-028 The package seq_detect_pkg SHALL hold the mode enum (NON_OVERLAP, OVERLAP) and the elaboration-time functions computing the border and the mismatch-fallback table from PATTERN and WIDTH.
REQ-029 Saturating counter logic SHALL be a sub-module match_counter (parameter CNT_W; inputs clk, rst, inc, clr; outputs cnt, sat).
REQ-030 The next-state decoder SHALL be a separate combinational block from the state register, with a default branch returning S=0.

Verification (WIDTH=4, PATTERN=1011, en=1 unless stated)
REQ-031 Reset: rst=1 for 2 cycles with random din, then 0 -> dout=0, state_o=0, match_cnt=0.
REQ-032 Overlap: OVERLAP=1, din=1,0,1,1,0,1,1 -> dout pulse after bits 4 and 7, match_cnt=2.
REQ-033 Non-overlap: OVERLAP=0, same stream -> single pulse after bit 4, match_cnt=1.
REQ-034 Fallback: din=1,1,0,1,1 -> state_o=1,1,2,3, then match pulse after bit 5.
REQ-035 Stall and reset: din=1,0, en=0 for 3 cycles with din toggling, en=1 with din=1,1 -> pulse after last bit. Repeat with rst=1 for 1 cycle after bits 1,0 -> no pulse.
REQ-036 Saturation: CNT_W=2, 4 overlapping matches -> match_cnt=3, cnt_sat=1. clr coincident with a 5th match -> match_cnt=0, dout still pulses.
